// File: rtl/mem_port_arbiter.sv
// Arbitrates the MIPS core's instruction-fetch and data ports onto one single-ported RAM.
// Data requests win; each completed result is held and the core stalls until all its requests are served.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        timeout_err
);

  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t     state;
  logic       i_srv;
  logic       d_srv;
  logic [7:0] tmo_cnt;
  logic       ireq;
  logic       dreq;
  logic       i_elig;
  logic       d_elig;
  logic       tmo_hit;

  assign ireq    = inst_ren;
  assign dreq    = mem_ren | mem_wen;
  assign i_elig  = ireq & ~i_srv;
  assign d_elig  = dreq & ~d_srv;
  assign stall   = i_elig | d_elig;
  // Abort on the BUSY cycle whose increment would bring the count up to the limit.
  assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= TMO_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      inst_data   <= '0;
      mem_din     <= '0;
      i_srv       <= 1'b0;
      d_srv       <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      // The core advances at the end of any non-stalled cycle; a dropped request also forgets its flag.
      if (!stall || !ireq) i_srv <= 1'b0;
      if (!stall || !dreq) d_srv <= 1'b0;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (d_elig) begin
            ram_req   <= 1'b1;
            ram_we    <= mem_wen;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_dout;
            state     <= BUSY_D;
          end else if (i_elig) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= inst_addr;
            state    <= BUSY_I;
          end
        end

        BUSY_I, BUSY_D: begin
          if (ram_ready) begin
            if (state == BUSY_I) begin
              inst_data <= ram_rdata;
              i_srv     <= 1'b1;
            end else begin
              if (!ram_we) mem_din <= ram_rdata;
              d_srv <= 1'b1;
            end
            ram_req <= 1'b0;
            state   <= IDLE;
          end else if (tmo_hit) begin
            // Give up: mark the port served with its old result so the core cannot hang.
            if (state == BUSY_I) i_srv <= 1'b1;
            else                 d_srv <= 1'b1;
            timeout_err <= 1'b1;
            tmo_cnt     <= tmo_cnt + 8'd1;
            ram_req     <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: begin
          ram_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected RAM accesses are queued as the core model
// issues requests and checked against every cycle of each ram_req burst.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        stall;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_rdata = 32'h0;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .stall(stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0) return 32'h20080005;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // RAM model and access monitor
  int   rdy_wait = 1;
  bit   hold_low = 1'b0;
  bit   stray    = 1'b0;
  int   busy_cnt = 0;
  int   last_len = 0;
  int   bursts   = 0;
  acc_t cur;

  always @(negedge clk) begin
    ram_ready = 1'b0;
    ram_rdata = 32'h0;
    if (ram_req) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        bursts++;
        check_eq("access_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else cur = '{32'hFFFF_FFFF, 1'b0, 32'h0};
      end
      check_eq("ram_addr", ram_addr, cur.addr);
      check_eq("ram_we", 32'(ram_we), 32'(cur.we));
      if (cur.we) check_eq("ram_wdata", ram_wdata, cur.wdata);
      if (!hold_low && busy_cnt == rdy_wait) begin
        ram_ready = 1'b1;
        ram_rdata = mem_val(ram_addr);
      end
    end else begin
      if (busy_cnt > 0) last_len = busy_cnt;
      busy_cnt = 0;
      if (stray) begin
        ram_ready = 1'b1;
        ram_rdata = 32'hBAD0BAD0;
        stray     = 1'b0;
      end
    end
  end

  task automatic idle_inputs();
    inst_ren  = 1'b0;
    inst_addr = 32'h0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'h0;
    mem_dout  = 32'h0;
  endtask

  // Core model: present requests, hold them while stalled, advance on the first non-stalled cycle.
  task automatic run_req(input string tag, input logic ir, input logic [31:0] ia,
                         input logic mr, input logic mw, input logic [31:0] ma,
                         input logic [31:0] md, input int exp_stall);
    int sc;
    sc        = 0;
    inst_ren  = ir;
    inst_addr = ia;
    mem_ren   = mr;
    mem_wen   = mw;
    mem_addr  = ma;
    mem_dout  = md;
    while (1) begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      if (sc > 100) break;
    end
    check_eq({tag, "_stall_cycles"}, 32'(sc), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] snap_i;
  logic [31:0] snap_d;
  int          b0;

  initial begin
    rst = 1'b1;
    idle_inputs();
    inst_ren = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ram_req", 32'(ram_req), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_ram_wdata", ram_wdata, 32'h0);
    check_eq("rst_inst_data", inst_data, 32'h0);
    check_eq("rst_mem_din", mem_din, 32'h0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd1);

    // First fetch after reset release: ram_req at cycle 1, result at cycle 2
    @(posedge clk); #1;
    rdy_wait = 1;
    exp_q.push_back('{32'h0, 1'b0, 32'h0});
    rst = 1'b0;
    @(negedge clk);
    check_eq("f0_req_c0", 32'(ram_req), 32'd0);
    check_eq("f0_stall_c0", 32'(stall), 32'd1);
    @(negedge clk);
    check_eq("f0_req_c1", 32'(ram_req), 32'd1);
    check_eq("f0_stall_c1", 32'(stall), 32'd1);
    @(negedge clk);
    check_eq("f0_stall_c2", 32'(stall), 32'd0);
    check_eq("f0_inst_data", inst_data, 32'h20080005);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    // Both ports, zero-wait RAM; a second pair follows straight after the single free cycle
    rdy_wait = 1;
    exp_q.push_back('{32'h100, 1'b0, 32'h0});
    exp_q.push_back('{32'h4, 1'b0, 32'h0});
    run_req("dual", 1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4);
    check_eq("dual_mem_din", mem_din, mem_val(32'h100));
    check_eq("dual_inst_data", inst_data, mem_val(32'h4));
    exp_q.push_back('{32'h104, 1'b0, 32'h0});
    exp_q.push_back('{32'h8, 1'b0, 32'h0});
    run_req("dual2", 1'b1, 32'h8, 1'b1, 1'b0, 32'h104, 32'h0, 4);
    check_eq("dual2_mem_din", mem_din, mem_val(32'h104));
    check_eq("dual2_inst_data", inst_data, mem_val(32'h8));
    idle_inputs();
    @(posedge clk); #1;

    // Write with 3-cycle RAM latency
    rdy_wait = 3;
    snap_d = mem_din;
    b0 = bursts;
    exp_q.push_back('{32'h200, 1'b1, 32'hDEADBEEF});
    run_req("wr", 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4);
    check_eq("wr_mem_din_kept", mem_din, snap_d);
    check_eq("wr_bursts", 32'(bursts - b0), 32'd1);
    check_eq("wr_burst_len", 32'(last_len), 32'd3);
    idle_inputs();
    @(posedge clk); #1;

    // Read and write together is a write
    rdy_wait = 1;
    exp_q.push_back('{32'h210, 1'b1, 32'h12345678});
    run_req("rw", 1'b0, 32'h0, 1'b1, 1'b1, 32'h210, 32'h12345678, 2);
    check_eq("rw_mem_din_kept", mem_din, snap_d);
    idle_inputs();
    @(posedge clk); #1;

    // Back-to-back fetches
    rdy_wait = 2;
    b0 = bursts;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'(4 * i), 1'b0, 32'h0});
      run_req("fetch", 1'b1, 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, 3);
      check_eq("fetch_inst_data", inst_data, mem_val(32'(4 * i)));
    end
    idle_inputs();
    @(negedge clk);
    check_eq("fetch_bursts", 32'(bursts - b0), 32'd3);
    check_eq("idle_stall", 32'(stall), 32'd0);
    check_eq("no_timeout_yet", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;

    // Stray ram_ready while IDLE must be ignored
    snap_i = inst_data;
    snap_d = mem_din;
    b0 = bursts;
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("stray_inst_data", inst_data, snap_i);
    check_eq("stray_mem_din", mem_din, snap_d);
    check_eq("stray_bursts", 32'(bursts - b0), 32'd0);

    // Timeout with RAM never answering
    hold_low = 1'b1;
    snap_i = inst_data;
    exp_q.push_back('{32'h40, 1'b0, 32'h0});
    run_req("tmo", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 5);
    check_eq("tmo_err", 32'(timeout_err), 32'd1);
    check_eq("tmo_inst_data_kept", inst_data, snap_i);
    check_eq("tmo_burst_len", 32'(last_len), 32'd4);
    hold_low = 1'b0;
    rdy_wait = 1;
    exp_q.push_back('{32'h44, 1'b0, 32'h0});
    run_req("after_tmo", 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2);
    check_eq("after_tmo_inst_data", inst_data, mem_val(32'h44));
    check_eq("tmo_err_sticky", 32'(timeout_err), 32'd1);
    idle_inputs();
    @(posedge clk); #1;

    // Reset during BUSY_D, then reissue
    hold_low = 1'b1;
    exp_q.push_back('{32'h300, 1'b0, 32'h0});
    mem_ren  = 1'b1;
    mem_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_d_req", 32'(ram_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_ram_req", 32'(ram_req), 32'd0);
    check_eq("midrst_stall", 32'(stall), 32'd1);
    check_eq("midrst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    hold_low = 1'b0;
    rdy_wait = 1;
    exp_q.push_back('{32'h300, 1'b0, 32'h0});
    rst = 1'b0;
    run_req("rst_retry", 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 2);
    check_eq("rst_retry_mem_din", mem_din, mem_val(32'h300));
    check_eq("rst_retry_len", 32'(last_len), 32'd1);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported external memory between the MIPS core's instruction-fetch port and its data port. It serialises requests with fixed data-first priority and holds each completed result. It drives a single pipeline stall until every request the core is presenting in the current cycle has been served. It sits between `mips_core` (`inst_*`, `mem_*` ports) and the unified RAM/bus.

## Interface
- `TIMEOUT`, default 255: maximum cycles `ram_req` waits for `ram_ready` before the access is aborted; 8-bit counter range.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_ren`  in  1  core instruction read request.
- `inst_addr`  in  32  instruction address.
- `inst_data`  out  32  held instruction result.
- `mem_ren`  in  1  core data read request.
- `mem_wen`  in  1  core data write request.
- `mem_addr`  in  32  data address.
- `mem_dout`  in  32  core write data.
- `mem_din`  out  32  held data-read result.
- `stall`  out  1  core must hold all pipeline registers this cycle.
- `ram_req`  out  1  access request to RAM.
- `ram_we`  out  1  write strobe; valid while `ram_req`.
- `ram_addr`  out  32  RAM address; valid while `ram_req`.
- `ram_wdata`  out  32  RAM write data; valid while `ram_req`.
- `ram_ready`  in  1  one-cycle completion pulse.
- `ram_rdata`  in  32  read data; valid with `ram_ready`.
- `timeout_err`  out  1  sticky; set on any timeout.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- Request lines:
  - `ireq = inst_ren`.
  - `dreq = mem_ren | mem_wen`.
  - If both `mem_ren` and `mem_wen` are high, the access is a write.
- Served flags `i_srv` and `d_srv` are registered. A port is eligible when it is requesting and its served flag is clear.
- `stall = (ireq & ~i_srv) | (dreq & ~d_srv)`. This is combinational from the inputs and the flags.
- IDLE:
  - If data is eligible, latch `mem_addr`, `mem_dout` and write-ness into the `ram_*` registers, then go to BUSY_D.
  - Otherwise, if instruction is eligible, latch `inst_addr` with `ram_we=0`, then go to BUSY_I.
  - Otherwise, stay in IDLE.
- BUSY_x:
  - `ram_req=1`; all `ram_*` registers are held stable.
  - On `ram_ready`: capture `ram_rdata` into `inst_data` (BUSY_I) or into `mem_din` (BUSY_D, reads only; a write leaves `mem_din` unchanged). Set the matching served flag and go to IDLE.
- Served flags clear on any cycle where `stall=0`, because the core advances at the end of that cycle. A flag whose port drops its request also clears.
- Timeout:
  - An 8-bit counter is cleared on entry to BUSY_x and increments each BUSY cycle without `ram_ready`.
  - When the count reaches `TIMEOUT`: set `timeout_err`, set the served flag with the result register unchanged, and go to IDLE. The core is therefore never hung.
- `ram_ready` received while in IDLE is ignored.
- Reset values (asynchronous):
  - state=IDLE.
  - `ram_req=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
  - `inst_data=0`, `mem_din=0`.
  - `i_srv=0`, `d_srv=0`.
  - `timeout_err=0`, counter=0.
  - `stall` then follows its equation, so it is high if any request is present.
- Reset asserted mid-access drops `ram_req` immediately and discards the access. The core reissues it after reset.

## Timing
- Single access, with the request at cycle 0 in IDLE and `ram_ready` arriving at cycle k ≥ 1:
  - `ram_req` is high from cycle 1 through cycle k.
  - The served flag is set at cycle k+1.
  - `stall` is low at cycle k+1 if no other port is pending.
- Minimum access latency is 2 cycles with `stall` high (cycles 0–1); `stall` is low at cycle 2.
- Both ports requesting with `ram_ready` at the first request cycle:
  - Data is served first: BUSY_D at cycle 1, IDLE at cycle 2.
  - BUSY_I at cycle 3.
  - `i_srv` set at cycle 4, so `stall` is low at cycle 4.
- In the cycle a flag is set (`stall` low), that port is not eligible. No duplicate access is issued before the core advances.
- `timeout_err` rises in the cycle after the counter reaches `TIMEOUT`. It stays high until reset.

## Test plan
- Reset with `inst_ren=1` and `inst_addr=0x0` -> all outputs at reset values and `stall=1`. After release: `ram_req` at cycle 1 with `ram_addr=0x0`; `ram_ready` with `ram_rdata=0x20080005` -> `inst_data=0x20080005` and `stall=0` one cycle later.
- `inst_ren=1` at `0x4` plus `mem_ren=1` at `0x100` with zero-wait RAM -> first `ram_addr=0x100`, then `ram_addr=0x4`. `mem_din` and `inst_data` are both loaded; `stall` is high for 4 cycles, then low for exactly 1 cycle.
- `mem_wen=1`, `mem_addr=0x200`, `mem_dout=0xDEADBEEF`, `ram_ready` delayed 3 cycles -> `ram_we=1` and `ram_wdata=0xDEADBEEF` stable for all 3 cycles; `mem_din` unchanged; exactly one `ram_req` burst.
- Back-to-back fetches at `0x0`, `0x4`, `0x8` with the core advancing on `stall=0` -> exactly three RAM accesses with no duplicate address, and the served flags clear after each advance.
- `TIMEOUT=4` with `ram_ready` held low -> `ram_req` drops and `timeout_err=1` after 4 BUSY cycles; `stall` falls; a following request is served normally.
- `rst` pulsed while in BUSY_D -> `ram_req=0` immediately; after release the pending data request is reissued from IDLE.
